// File: rtl/alu_share_arbiter_pkg.sv
// ============================================================================
// Module   : alu_share_arbiter_pkg
// Brief    : Shared types for the ALU sharing arbiter and its ALU interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_arbiter_pkg;

    typedef logic [31:0] bus_type;

    // Encodings outside this set reach the ALU unchanged and fall to its default.
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_oper_type;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } alu_arb_state_type;

endpackage : alu_share_arbiter_pkg

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sequencer sharing one combinational ALU among requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  bus_type             req_a   [NUM_REQ],
    input  bus_type             req_b   [NUM_REQ],
    input  alu_oper_type        req_sel [NUM_REQ],
    output logic [NUM_REQ-1:0]  rsp_valid,
    input  logic [NUM_REQ-1:0]  rsp_ready,
    output bus_type             rsp_result,
    output logic                rsp_zero,
    output bus_type             alu_a,
    output bus_type             alu_b,
    output alu_oper_type        alu_sel,
    input  bus_type             alu_s,
    input  logic                alu_zero,
    output logic                busy,
    output logic [IDX_W-1:0]    grant_id
);

    alu_arb_state_type state;
    alu_arb_state_type next_state;

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              rsp_done;

    bus_type           a_q;
    bus_type           b_q;
    alu_oper_type      sel_q;
    bus_type           result_q;
    logic              zero_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rsp_done   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    next_state = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                next_state = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_done = rsp_ready[owner];
                if (rsp_done) begin
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // The pointer only moves on response completion, so a stalled owner keeps its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            owner    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= ALU_ADD;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if ((state == ARB_IDLE) && pick_found) begin
                owner <= pick_idx;
                a_q   <= req_a[pick_idx];
                b_q   <= req_b[pick_idx];
                sel_q <= req_sel[pick_idx];
            end
            if (state == ARB_EXEC) begin
                result_q <= alu_s;
                zero_q   <= alu_zero;
            end
            if (rsp_done) begin
                rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign req_ready[i] = (state == ARB_IDLE) && pick_found && (pick_idx == IDX_W'(i));
        assign rsp_valid[i] = (state == ARB_RESP) && (owner == IDX_W'(i));
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign busy       = (state != ARB_IDLE);
    assign grant_id   = owner;

endmodule : alu_share_arbiter

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Scoreboard bench for alu_share_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    bus_type        req_a   [N];
    bus_type        req_b   [N];
    alu_oper_type   req_sel [N];
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    bus_type        rsp_result;
    logic           rsp_zero;
    bus_type        alu_a;
    bus_type        alu_b;
    alu_oper_type   alu_sel;
    bus_type        alu_s;
    logic           alu_zero;
    logic           busy;
    logic [0:0]     grant_id;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_s      (alu_s),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Reference ALU sitting next to the arbiter; unknown encodings act as AND.
    always_comb begin
        case (alu_sel)
            ALU_AND: alu_s = alu_a & alu_b;
            ALU_OR:  alu_s = alu_a | alu_b;
            ALU_ADD: alu_s = alu_a + alu_b;
            ALU_SUB: alu_s = alu_a - alu_b;
            ALU_SLT: alu_s = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_s = alu_a & alu_b;
        endcase
        alu_zero = (alu_s == 32'd0);
    end

    typedef struct { alu_oper_type sel; bus_type a; bus_type b; } op_t;
    typedef struct { int idx; bus_type res; logic zero; } exp_t;

    op_t   opq0[$];
    op_t   opq1[$];
    exp_t  exp_q[$];
    int    acc_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic [N-1:0] took;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic push_op(int i, alu_oper_type s, bus_type a, bus_type b,
                           bus_type r, logic z, bit expect_rsp);
        op_t  o;
        exp_t e;
        o.sel = s; o.a = a; o.b = b;
        if (i == 0) opq0.push_back(o); else opq1.push_back(o);
        if (expect_rsp) begin
            e.idx = i; e.res = r; e.zero = z;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || opq0.size() != 0 || opq1.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", name}, 64'(n < 200), 64'd1);
    endtask

    // Driver: present the head of each requester queue, retire it once accepted.
    initial begin
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = '0; req_b[i] = '0; req_sel[i] = ALU_ADD;
        end
        forever begin
            @(negedge clk);
            took = req_ready & req_valid;
            @(posedge clk);
            #1;
            if (took[0] && opq0.size() > 0) void'(opq0.pop_front());
            if (took[1] && opq1.size() > 0) void'(opq1.pop_front());
            if (opq0.size() > 0) begin
                req_valid[0] = 1'b1; req_a[0] = opq0[0].a; req_b[0] = opq0[0].b; req_sel[0] = opq0[0].sel;
            end else begin
                req_valid[0] = 1'b0;
            end
            if (opq1.size() > 0) begin
                req_valid[1] = 1'b1; req_a[1] = opq1[0].a; req_b[1] = opq1[0].b; req_sel[1] = opq1[0].sel;
            end else begin
                req_valid[1] = 1'b0;
            end
        end
    end

    // Monitor: latency, stability and scoreboard comparison on each handshake.
    logic [N-1:0] prev_rv = '0;
    bus_type      prev_res = '0;
    logic         prev_hs = 1'b0;
    logic         hs;
    int           ridx;
    exp_t         e;

    initial begin
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (!rst_n) begin
                acc_q.delete();
                prev_rv = '0;
                prev_hs = 1'b0;
                continue;
            end
            if (req_ready != '0) begin
                check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                acc_q.push_back(cyc);
            end
            if (rsp_valid != '0) begin
                check("rsp_valid_onehot", 64'($onehot(rsp_valid)), 64'd1);
                check("req_ready_while_rsp", 64'(req_ready), 64'd0);
                if (prev_rv == '0 || prev_hs) begin
                    if (acc_q.size() == 0) fail("rsp_without_accept");
                    else check("rsp_latency", 64'(cyc), 64'(acc_q.pop_front() + 2));
                end else begin
                    check("rsp_valid_stable", 64'(rsp_valid), 64'(prev_rv));
                    check("rsp_result_stable", 64'(rsp_result), 64'(prev_res));
                end
                hs = |(rsp_valid & rsp_ready);
                if (hs) begin
                    ridx = rsp_valid[1] ? 1 : 0;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_idx", 64'(ridx), 64'(e.idx));
                        check("rsp_result", 64'(rsp_result), 64'(e.res));
                        check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
                        check("grant_id", 64'(grant_id), 64'(e.idx));
                    end
                end
            end
            prev_rv  = rsp_valid;
            prev_res = rsp_result;
            prev_hs  = hs;
        end
    end

    task automatic check_reset_outputs(string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({name, "_req_ready"}, 64'(req_ready), 64'd0);
        check({name, "_grant_id"}, 64'(grant_id), 64'd0);
        check({name, "_alu_a"}, 64'(alu_a), 64'd0);
        check({name, "_alu_sel"}, 64'(alu_sel), 64'(ALU_ADD));
        check({name, "_rsp_result"}, 64'(rsp_result), 64'd0);
        check({name, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    endtask

    logic [2:0] raw_sel = 3'b011;
    int         n;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 2'b11;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single request and zero flag
        push_op(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        wait_drain("single");
        push_op(1, ALU_SUB, 32'h10, 32'h10, 32'd0, 1'b1, 1'b1);
        wait_drain("zero");

        // Simultaneous requests right after reset: index 0 first
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        push_op(0, ALU_OR,  32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b1);
        push_op(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1);
        wait_drain("simultaneous");

        // Fairness: grants alternate 0,1,0,1,0,1
        push_op(0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
        push_op(1, ALU_AND, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0, 1'b1);
        push_op(0, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
        push_op(1, ALU_SLT, 32'd5, 32'd3, 32'd0, 1'b1, 1'b1);
        push_op(0, ALU_OR,  32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        push_op(1, alu_oper_type'(raw_sel), 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b1);
        wait_drain("fairness");

        // Back-pressure on requester 0 while requester 1 waits
        rsp_ready[0] = 1'b0;
        push_op(0, ALU_ADD, 32'h100, 32'h23, 32'h123, 1'b0, 1'b1);
        push_op(1, ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_seen", 64'(rsp_valid[0]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'b01);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_result", 64'(rsp_result), 64'h123);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_handshake", 64'(rsp_valid[0] & rsp_ready[0]), 64'd1);
        @(negedge clk);
        check("bp_next_accept", 64'(req_ready), 64'b10);
        wait_drain("backpressure");

        // Reset during ARB_EXEC drops the transaction
        push_op(0, ALU_ADD, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0);
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_accept", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #2;
        check("mid_busy_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_rsp", 64'(rsp_valid), 64'd0);
        push_op(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
        wait_drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_share_arbiter

`default_nettype wire
